bsg_front_side_bus_hop_out: RTL

BSG_FRONT_SIDE_BUS_HOP_OUT -- requirements
Module: bsg_front_side_bus_hop_out

---
 rtl/bsg_front_side_bus_hop_out.sv | 133 +++++++++++++
 1 files changed

// File: rtl/bsg_front_side_bus_hop_out.sv
// bsg_front_side_bus_hop_out
//
// Output hop of a front-side bus ring node. Upstream bus traffic always takes
// the outgoing slot; the local node's words wait in a small FIFO and fill any
// cycle the upstream bus leaves idle. A saturating counter tracks how long the
// local head entry has been waiting while upstream holds the bus, and raises
// an advisory starvation flag when the counter reaches its limit.
//
// Ports
//   clk_i          sole clock, rising edge
//   reset_n_i      asynchronous, active-low reset
//   hop_data_i     upstream bus data (no flow control)
//   hop_v_i        upstream bus valid
//   local_data_i   data from the local node
//   local_v_i      local valid
//   local_ready_o  local queue not full (registered state only)
//   data_o         registered outgoing bus data
//   v_o            registered outgoing bus valid
//   starve_o       registered flag: local head entry is being starved
module bsg_front_side_bus_hop_out #(
  parameter int width_p        = 16,
  parameter int local_els_p    = 2,
  parameter int starve_limit_p = 15
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] hop_data_i,
  input  logic               hop_v_i,
  input  logic [width_p-1:0] local_data_i,
  input  logic               local_v_i,
  output logic               local_ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  output logic               starve_o
);

  localparam int ptr_w_lp = (local_els_p > 1) ? $clog2(local_els_p) : 1;
  localparam int cnt_w_lp = $clog2(local_els_p + 1);
  localparam int stv_w_lp = $clog2(starve_limit_p + 1);

  localparam logic [cnt_w_lp-1:0] full_cnt_lp   = cnt_w_lp'(local_els_p);
  localparam logic [stv_w_lp-1:0] starve_max_lp = stv_w_lp'(starve_limit_p);

  // Saturating increment of the starvation counter.
  function automatic logic [stv_w_lp-1:0] sat_inc(input logic [stv_w_lp-1:0] val);
    if (val == starve_max_lp) return val;
    else                      return val + stv_w_lp'(1);
  endfunction

  logic [width_p-1:0]  mem_q [local_els_p];

  logic [ptr_w_lp-1:0] rd_ptr_q, rd_ptr_d;
  logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d;
  logic [cnt_w_lp-1:0] count_q, count_d;
  logic [stv_w_lp-1:0] starve_cnt_q, starve_cnt_d;
  logic [width_p-1:0]  data_q, data_d;
  logic                v_q, v_d;
  logic                starve_q, starve_d;

  logic full, empty, enq, deq;

  // ---- next-state decode (registered state + inputs) ----
  always_comb begin
    full  = (count_q == full_cnt_lp);
    empty = (count_q == '0);
    // Ready depends only on count_q, so a dequeue in a full cycle cannot
    // open a slot for an enqueue in that same cycle.
    enq   = local_v_i & ~full;
    // No bypass: only words already stored can be dequeued.
    deq   = ~hop_v_i & ~empty;

    data_d       = data_q;
    v_d          = 1'b0;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    starve_cnt_d = starve_cnt_q;

    if (hop_v_i) begin
      data_d = hop_data_i;
      v_d    = 1'b1;
    end else if (!empty) begin
      data_d = mem_q[rd_ptr_q];
      v_d    = 1'b1;
    end

    if (enq) wr_ptr_d = wr_ptr_q + ptr_w_lp'(1);
    if (deq) rd_ptr_d = rd_ptr_q + ptr_w_lp'(1);

    case ({enq, deq})
      2'b10:   count_d = count_q + cnt_w_lp'(1);
      2'b01:   count_d = count_q - cnt_w_lp'(1);
      default: count_d = count_q;
    endcase

    if (deq || empty)  starve_cnt_d = '0;
    else if (hop_v_i)  starve_cnt_d = sat_inc(starve_cnt_q);

    starve_d = (starve_cnt_d == starve_max_lp);
  end

  // ---- registered state ----
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      starve_cnt_q <= '0;
      data_q       <= '0;
      v_q          <= 1'b0;
      starve_q     <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      starve_cnt_q <= starve_cnt_d;
      data_q       <= data_d;
      v_q          <= v_d;
      starve_q     <= starve_d;
    end
  end

  // Storage is not reset; stale contents are unreachable once count is 0.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wr_ptr_q] <= local_data_i;
  end

  assign local_ready_o = ~full;
  assign data_o        = data_q;
  assign v_o           = v_q;
  assign starve_o      = starve_q;

endmodule
